// File: rtl/vec_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_store_pkg
// Description : Shared encodings for the strided vector store engine (vsse.v):
//               vsew codes, FSM state enum, byte-strobe base patterns and the
//               element-size helper.
// Config      : VEC_STORE_SPLIT_EN adds the WRITE_HI state used for
//               word-crossing elements.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_store_pkg;

  localparam logic [1:0] VSEW_E8   = 2'b00;
  localparam logic [1:0] VSEW_E16  = 2'b01;
  localparam logic [1:0] VSEW_E32  = 2'b10;
  localparam logic [1:0] VSEW_RSVD = 2'b11;

  // Strobe patterns for an element sitting at byte lane 0.
  localparam logic [3:0] STRB_E8  = 4'b0001;
  localparam logic [3:0] STRB_E16 = 4'b0011;
  localparam logic [3:0] STRB_E32 = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WRITE,
    S_DONE
`ifdef VEC_STORE_SPLIT_EN
    ,
    S_WRITE_HI
`endif
  } state_e;

  // Element size in bytes; the reserved code is treated as 32-bit.
  function automatic logic [2:0] sew_bytes(input logic [1:0] sew);
    case (sew)
      VSEW_E8:  sew_bytes = 3'd1;
      VSEW_E16: sew_bytes = 3'd2;
      default:  sew_bytes = 3'd4;
    endcase
  endfunction

endpackage : vec_store_pkg
`default_nettype wire

// File: rtl/vec_store_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : vec_store_lane_align
// Description : Combinational lane alignment for one vector element. Replicates
//               the element across the word, rotates it to its byte offset and
//               builds the low/high word strobes.
// Ports       : elem_i[31:0]     element value (upper bits ignored for e8/e16)
//               sew_i[1:0]       element width code
//               off_i[1:0]       byte offset of the element within its word
//               wdata_o[31:0]    lane-aligned write data (shared by both halves)
//               wstrb_lo_o[3:0]  strobes for the word holding byte 0
//               wstrb_hi_o[3:0]  strobes spilling into the following word
//               crosses_o        element spans a word boundary
// Config      : none (used by both VEC_STORE_SPLIT_EN builds)
// Revision    : 1.0 - initial release
// ============================================================================
module vec_store_lane_align
  import vec_store_pkg::*;
(
  input  logic [31:0] elem_i,
  input  logic [1:0]  sew_i,
  input  logic [1:0]  off_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_lo_o,
  output logic [3:0]  wstrb_hi_o,
  output logic        crosses_o
);

  logic [31:0] rep;
  logic [3:0]  strb_base;
  logic [63:0] rot2;
  logic [7:0]  strb_wide;

  always_comb begin
    rep       = elem_i;
    strb_base = STRB_E32;
    case (sew_i)
      VSEW_E8: begin
        rep       = {4{elem_i[7:0]}};
        strb_base = STRB_E8;
      end
      VSEW_E16: begin
        rep       = {2{elem_i[15:0]}};
        strb_base = STRB_E16;
      end
      default: ;
    endcase
  end

  // Rotate-left by 8*off: upper half of the doubled word shifted left.
  assign rot2    = {rep, rep} << {off_i, 3'b000};
  assign wdata_o = rot2[63:32];

  // Strobes shifted past bit 3 are the bytes that belong to the next word.
  assign strb_wide  = {4'b0000, strb_base} << off_i;
  assign wstrb_lo_o = strb_wide[3:0];
  assign wstrb_hi_o = strb_wide[7:4];
  assign crosses_o  = |strb_wide[7:4];

endmodule : vec_store_lane_align
`default_nettype wire

// File: rtl/vec_strided_store.sv
`default_nettype none
// ============================================================================
// Module      : vec_strided_store
// Description : Strided vector store engine (vsse.v). Latches a vector register
//               image, base, stride, vl and SEW on start, then issues one
//               byte-strobed word write per element on a valid/ready port.
// Ports       : clk, resetn (async, active low)
//               start, base_addr[31:0], stride[31:0], vl[31:0], vsew[1:0],
//               vreg_data[VLEN-1:0]         - request side
//               busy, done, err             - status (err valid with done)
//               mem_valid, mem_ready, mem_addr[31:0], mem_wdata[31:0],
//               mem_wstrb[3:0]              - memory write port
// Config      : VEC_STORE_SPLIT_EN defined  -> word-crossing elements are
//               written as two transfers (WRITE, WRITE_HI).
//               VEC_STORE_SPLIT_EN undefined -> a crossing element ends the
//               operation with err=1, earlier elements stay written.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_strided_store
  import vec_store_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int IDX_W = $clog2(VLEN/8) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [31:0]     base_addr,
  input  logic [31:0]     stride,
  input  logic [31:0]     vl,
  input  logic [1:0]      vsew,
  input  logic [VLEN-1:0] vreg_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb
);

  state_e            state_q;
  logic [VLEN-1:0]   vreg_q;
  logic [31:0]       stride_q;
  logic [31:0]       cur_addr_q;
  logic [1:0]        sew_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  n_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_valid_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic [IDX_W-1:0]  vlmax_d;
  logic [IDX_W-1:0]  n_d;
  logic              last_d;
  logic [IDX_W+4:0]  elem_bit_off;
  logic [31:0]       lane_elem;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_wstrb_lo;
  logic [3:0]        lane_wstrb_hi;
  logic              lane_crosses;

  // Effective element count: vl clamped to VLEN/SEW without raising err.
  assign vlmax_d = IDX_W'((VLEN/8) >> vsew);
  assign n_d     = (vl > 32'(vlmax_d)) ? vlmax_d : vl[IDX_W-1:0];
  assign last_d  = (cnt_q == n_q - IDX_W'(1));

  assign elem_bit_off = (IDX_W+5)'({cnt_q, 3'b000}) * (IDX_W+5)'(sew_bytes(sew_q));
  assign lane_elem    = 32'(vreg_q >> elem_bit_off);

  vec_store_lane_align u_align (
    .elem_i     (lane_elem),
    .sew_i      (sew_q),
    .off_i      (cur_addr_q[1:0]),
    .wdata_o    (lane_wdata),
    .wstrb_lo_o (lane_wstrb_lo),
    .wstrb_hi_o (lane_wstrb_hi),
    .crosses_o  (lane_crosses)
  );

`ifdef VEC_STORE_SPLIT_EN
  logic       crosses_q;
  logic [3:0] wstrb_hi_q;
`else
  // High-spill strobes only matter when crossing elements are split.
  logic unused_wstrb_hi;
  assign unused_wstrb_hi = ^lane_wstrb_hi;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      vreg_q      <= '0;
      stride_q    <= '0;
      cur_addr_q  <= '0;
      sew_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
`ifdef VEC_STORE_SPLIT_EN
      crosses_q   <= 1'b0;
      wstrb_hi_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            vreg_q     <= vreg_data;
            stride_q   <= stride;
            sew_q      <= vsew;
            cur_addr_q <= base_addr;
            cnt_q      <= '0;
            n_q        <= n_d;
            busy_q     <= 1'b1;
            if (vsew == VSEW_RSVD) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (n_d == '0) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
`ifndef VEC_STORE_SPLIT_EN
          if (lane_crosses) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else
`endif
          begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {cur_addr_q[31:2], 2'b00};
            mem_wdata_q <= lane_wdata;
            mem_wstrb_q <= lane_wstrb_lo;
`ifdef VEC_STORE_SPLIT_EN
            crosses_q   <= lane_crosses;
            wstrb_hi_q  <= lane_wstrb_hi;
`endif
            state_q     <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
`ifdef VEC_STORE_SPLIT_EN
            if (crosses_q) begin
              // Second half of the element: same data, next word.
              mem_wstrb_q <= wstrb_hi_q;
              mem_addr_q  <= mem_addr_q + 32'd4;
              state_q     <= S_WRITE_HI;
            end else
`endif
            begin
              mem_valid_q <= 1'b0;
              cnt_q       <= cnt_q + IDX_W'(1);
              cur_addr_q  <= cur_addr_q + stride_q;
              done_q      <= last_d;
              state_q     <= last_d ? S_DONE : S_ADDR;
            end
          end
        end

`ifdef VEC_STORE_SPLIT_EN
        S_WRITE_HI: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            cnt_q       <= cnt_q + IDX_W'(1);
            cur_addr_q  <= cur_addr_q + stride_q;
            done_q      <= last_d;
            state_q     <= last_d ? S_DONE : S_ADDR;
          end
        end
`endif

        S_DONE: begin
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule : vec_strided_store
`default_nettype wire

// File: tb/tb_vec_strided_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_strided_store
// Description : Directed self-checking bench for vec_strided_store. A responder
//               answers each write with a one-cycle mem_ready pulse one cycle
//               after mem_valid is seen, and logs every accepted write.
//               Latency below = posedges from the one sampling start up to and
//               including the one after which done reads high.
// Config      : follows VEC_STORE_SPLIT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_strided_store;

  localparam int VLEN = 256;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     base_addr = '0;
  logic [31:0]     stride = '0;
  logic [31:0]     vl = '0;
  logic [1:0]      vsew = '0;
  logic [VLEN-1:0] vreg_data = '0;
  logic            busy, done, err;
  logic            mem_valid;
  logic            mem_ready = 1'b0;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;

  logic            hold = 1'b0;
  logic [31:0]     log_addr[$];
  logic [3:0]      log_strb[$];
  logic [31:0]     log_data[$];

  int n_checks = 0;
  int n_fail   = 0;

  vec_strided_store #(.VLEN(VLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .vl        (vl),
    .vsew      (vsew),
    .vreg_data (vreg_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 clk = ~clk;

  // Responder and write logger.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
    end else begin
      if (mem_valid && mem_ready) begin
        log_addr.push_back(mem_addr);
        log_strb.push_back(mem_wstrb);
        log_data.push_back(mem_wdata);
      end
      mem_ready <= mem_valid && !mem_ready && !hold;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_strb.delete();
    log_data.delete();
  endtask

  task automatic run_op(input logic [1:0] s, input logic [31:0] b, input logic [31:0] st,
                        input logic [31:0] n, input logic [VLEN-1:0] v,
                        output int lat, output logic e);
    @(posedge clk); #1;
    vsew = s; base_addr = b; stride = st; vl = n; vreg_data = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    e = err;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: done never seen after %0d cycles", lat);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, err, mem_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, err, mem_valid});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h/%b want 0", mem_addr, mem_wdata, mem_wstrb);
    end
  endtask

  task automatic test_e8_stride2();
    int lat; logic e;
    logic [VLEN-1:0] v;
    v = '0;
    v[63:0] = 64'h0807_0605_0403_0201;
    clear_log();
    run_op(2'b00, 32'd400, 32'd2, 32'd8, v, lat, e);
    n_checks++;
    if (lat !== 25 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL e8_latency: got %0d err %b want 25 err 0", lat, e);
    end
    n_checks++;
    if (log_addr.size() !== 8) begin
      n_fail++;
      $display("FAIL e8_count: got %0d want 8", log_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [31:0] ea; logic [3:0] es; logic [31:0] ed;
        ea = 32'd400 + 32'(4 * (i / 2));
        es = (i % 2 == 0) ? 4'b0001 : 4'b0100;
        ed = {4{8'(i + 1)}};
        n_checks++;
        if (log_addr[i] !== ea || log_strb[i] !== es || log_data[i] !== ed) begin
          n_fail++;
          $display("FAIL e8_write%0d: got %0d/%b/%h want %0d/%b/%h",
                   i, log_addr[i], log_strb[i], log_data[i], ea, es, ed);
        end
      end
    end
  endtask

  task automatic test_e32_negative_stride();
    int lat; logic e;
    logic [VLEN-1:0] v;
    logic [31:0] words[3];
    words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
    v = '0;
    v[95:0] = {words[2], words[1], words[0]};
    clear_log();
    run_op(2'b10, 32'd420, 32'hFFFF_FFFC, 32'd3, v, lat, e);
    n_checks++;
    if (lat !== 10 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL e32_latency: got %0d err %b want 10 err 0", lat, e);
    end
    n_checks++;
    if (log_addr.size() !== 3) begin
      n_fail++;
      $display("FAIL e32_count: got %0d want 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (log_addr[i] !== 32'(420 - 4 * i) || log_strb[i] !== 4'b1111 || log_data[i] !== words[i]) begin
          n_fail++;
          $display("FAIL e32_write%0d: got %0d/%b/%h want %0d/1111/%h",
                   i, log_addr[i], log_strb[i], log_data[i], 420 - 4 * i, words[i]);
        end
      end
    end
  endtask

  task automatic test_split();
    int lat; logic e;
    logic [VLEN-1:0] v;
    v = '0;
    v[15:0] = 16'hBEEF;
    clear_log();
    run_op(2'b01, 32'd403, 32'd0, 32'd1, v, lat, e);
`ifdef VEC_STORE_SPLIT_EN
    n_checks++;
    if (lat !== 6 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL split_latency: got %0d err %b want 6 err 0", lat, e);
    end
    n_checks++;
    if (log_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL split_count: got %0d want 2", log_addr.size());
    end else begin
      n_checks++;
      if (log_addr[0] !== 32'd400 || log_strb[0] !== 4'b1000 || log_data[0] !== 32'hEFBEEFBE) begin
        n_fail++;
        $display("FAIL split_lo: got %0d/%b/%h want 400/1000/efbeefbe", log_addr[0], log_strb[0], log_data[0]);
      end
      n_checks++;
      if (log_addr[1] !== 32'd404 || log_strb[1] !== 4'b0001 || log_data[1] !== 32'hEFBEEFBE) begin
        n_fail++;
        $display("FAIL split_hi: got %0d/%b/%h want 404/0001/efbeefbe", log_addr[1], log_strb[1], log_data[1]);
      end
    end
`else
    n_checks++;
    if (e !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL nosplit_err: got err %b lat %0d want err 1 lat 2", e, lat);
    end
    n_checks++;
    if (log_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL nosplit_writes: got %0d want 0", log_addr.size());
    end
`endif
  endtask

  task automatic test_empty_and_reserved();
    int lat; logic e;
    clear_log();
    run_op(2'b00, 32'd0, 32'd1, 32'd0, '1, lat, e);
    n_checks++;
    if (lat !== 1 || e !== 1'b0 || log_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL vl0: got lat %0d err %b writes %0d want 1/0/0", lat, e, log_addr.size());
    end
    run_op(2'b11, 32'd0, 32'd1, 32'd4, '1, lat, e);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || log_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL vsew11: got lat %0d err %b writes %0d want 1/1/0", lat, e, log_addr.size());
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_done: got busy/done/err %b want 000", {busy, done, err});
    end
  endtask

  // vl clamped to 32 e8 elements; start pulses during the run must be dropped.
  task automatic test_clamp_and_ignore();
    int cyc;
    logic [VLEN-1:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(i);
    clear_log();
    @(posedge clk); #1;
    vsew = 2'b00; base_addr = 32'd0; stride = 32'd1; vl = 32'd100; vreg_data = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vl = 32'd1; base_addr = 32'h0000_8000;
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 5 || cyc == 40);
    end
    start = 1'b0;
    n_checks++;
    if (!done || log_addr.size() !== 32) begin
      n_fail++;
      $display("FAIL clamp_count: got %0d writes done %b want 32 done 1", log_addr.size(), done);
    end else begin
      n_checks++;
      if (log_addr[31] !== 32'd28 || log_strb[31] !== 4'b1000 || log_data[31] !== 32'h1F1F1F1F) begin
        n_fail++;
        $display("FAIL clamp_last: got %0d/%b/%h want 28/1000/1f1f1f1f", log_addr[31], log_strb[31], log_data[31]);
      end
    end
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || log_addr.size() !== 32) begin
      n_fail++;
      $display("FAIL ignore_start: got busy %b writes %0d want 0/32", busy, log_addr.size());
    end
  endtask

  task automatic test_hold_stable();
    int lat; logic e; int w;
    logic [VLEN-1:0] v;
    v = '0;
    v[31:0] = 32'h1234_5678;
    clear_log();
    hold = 1'b1;
    @(posedge clk); #1;
    vsew = 2'b10; base_addr = 32'h100; stride = 32'd4; vl = 32'd1; vreg_data = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!mem_valid && w < 50) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'b1111) begin
        n_fail++;
        $display("FAIL hold_stable%0d: got %b %h/%h/%b want 1 100/12345678/1111",
                 i, mem_valid, mem_addr, mem_wdata, mem_wstrb);
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
    e = err;
    n_checks++;
    if (!done || e !== 1'b0 || log_addr.size() !== 1) begin
      n_fail++;
      $display("FAIL hold_release: got done %b err %b writes %0d want 1/0/1", done, e, log_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic e; int w;
    logic [VLEN-1:0] v;
    v = '0;
    v[95:0] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    clear_log();
    hold = 1'b1;
    @(posedge clk); #1;
    vsew = 2'b10; base_addr = 32'h200; stride = 32'd4; vl = 32'd3; vreg_data = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!mem_valid && w < 50) begin @(posedge clk); #1; w++; end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({mem_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: got valid/busy/done %b want 000", {mem_valid, busy, done});
    end
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    n_checks++;
    if (log_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_nowrite: got %0d writes want 0", log_addr.size());
    end
    run_op(2'b10, 32'h300, 32'd4, 32'd1, v, lat, e);
    n_checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 32'h300 || log_data[0] !== 32'h1111_1111 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d writes first %h/%h err %b want 1 300/11111111 0",
               log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'h0,
               (log_data.size() > 0) ? log_data[0] : 32'h0, e);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    test_e8_stride2();
    test_e32_negative_stride();
    test_split();
    test_empty_and_reserved();
    test_clamp_and_ignore();
    test_hold_stable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vec_strided_store
`default_nettype wire
